sram_burst_ctrl: RTL

//  Parametrised successor to the BeMicro 16-bit SRAM controller; sits between the core's 32-bit

---
 rtl/sram_burst_ctrl_if.sv | 25 ++
 rtl/sram_burst_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_burst_ctrl_if.sv
// Core-side memory port of the SRAM burst controller.
// Carries id-tagged burst reads and byte-masked single-word writes.
interface sram_burst_ctrl_if #(
    parameter int ID_W = 2
);
    logic            mem_waitrequest;
    logic [ID_W-1:0] mem_id;
    logic [29:0]     mem_address;
    logic            mem_read;
    logic            mem_write;
    logic [31:0]     mem_writedata;
    logic [3:0]      mem_writedatamask;
    logic [31:0]     mem_readdata;
    logic [ID_W-1:0] mem_readdataid;

    modport master (
        input  mem_waitrequest, mem_readdata, mem_readdataid,
        output mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
    );

    modport slave (
        output mem_waitrequest, mem_readdata, mem_readdataid,
        input  mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
    );
endinterface

// File: rtl/sram_burst_ctrl.sv
// Bridges a 32-bit id-tagged memory port to one asynchronous SRAM of 8/16/32-bit width,
// with burst reads, skipped masked write beats and a read-to-write bus turnaround gap.
module sram_burst_ctrl #(
    parameter int FREQ       = 50000000,
    parameter int tRC        = 55,
    parameter int tWP        = 45,
    parameter int SRAM_DW    = 16,
    parameter int SRAM_AW    = 18,
    parameter int BURST      = 4,
    parameter int ID_W       = 2,
    parameter int TURNAROUND = 1
) (
    input  logic                 clock,
    input  logic                 rst,
    sram_burst_ctrl_if.slave     bus,
    output logic [SRAM_AW-1:0]   sram_a,
    inout  wire  [SRAM_DW-1:0]   sram_d,
    output logic                 sram_cs_n,
    output logic [SRAM_DW/8-1:0] sram_be_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n
);
    localparam int     K        = 32 / SRAM_DW;
    localparam int     BPB      = SRAM_DW / 8;
    localparam longint NS_PER_S = 64'sd1000000000;
    localparam int     RWAIT    = 1 + int'((longint'(tRC) * longint'(FREQ)) / NS_PER_S);
    localparam int     WWAIT    = 1 + int'((longint'(tWP) * longint'(FREQ)) / NS_PER_S);
    localparam int     NBEATS   = BURST * K;
    localparam int     CMAX0    = (RWAIT > WWAIT) ? RWAIT : WWAIT;
    localparam int     CMAX     = (CMAX0 > TURNAROUND) ? CMAX0 : TURNAROUND;
    localparam int     CW       = $clog2(CMAX + 1);
    localparam int     BW       = $clog2(NBEATS + 1);
    localparam int     KW       = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_TURN, S_WSETUP, S_WPULSE, S_WHOLD
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [K-1:0]        pend_q, pend_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wmask_q, wmask_d;
    logic [SRAM_AW-1:0]  base_q, base_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     rid_q, rid_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                turn_q, turn_d;
    logic [SRAM_AW-1:0]  sram_a_q, sram_a_d;
    logic                cs_n_q, cs_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic [BPB-1:0]      be_n_q, be_n_d;
    logic [SRAM_DW-1:0]  dout_q, dout_d;
    logic                drive_q, drive_d;

    logic [K-1:0]        req_nz;
    logic [31:0]         rdata_shift;
    logic [SRAM_AW-1:0]  req_base;
    logic [K-1:0]        pend_src;
    logic [31:0]         wsrc_data;
    logic [3:0]          wsrc_mask;
    logic [SRAM_AW-1:0]  base_src;
    logic                first_ok;
    logic [KW-1:0]       first_idx;
    logic [SRAM_AW-1:0]  setup_a;
    logic [SRAM_DW-1:0]  setup_d;
    logic [BPB-1:0]      setup_be_n;
    logic                do_setup;

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_lane
            assign req_nz[gi] = |bus.mem_writedatamask[gi*BPB +: BPB];
        end
        // Beats enter at the top so that beat 0 ends up in the least significant lane.
        if (K == 1) begin : g_shift_full
            assign rdata_shift = sram_d;
        end else begin : g_shift_part
            assign rdata_shift = {sram_d, rdata_q[31:SRAM_DW]};
        end
    endgenerate

    assign req_base = SRAM_AW'({2'b00, bus.mem_address} * 32'(K));

    // In IDLE the beat plan comes straight off the request; later it comes from the latched copy.
    always_comb begin
        pend_src  = (state_q == S_IDLE) ? req_nz : pend_q;
        wsrc_data = (state_q == S_IDLE) ? bus.mem_writedata : wdata_q;
        wsrc_mask = (state_q == S_IDLE) ? bus.mem_writedatamask : wmask_q;
        base_src  = (state_q == S_IDLE) ? req_base : base_q;
        first_ok  = 1'b0;
        first_idx = '0;
        for (int i = K - 1; i >= 0; i--) begin
            if (pend_src[i]) begin
                first_ok  = 1'b1;
                first_idx = KW'(i);
            end
        end
        setup_a    = base_src + SRAM_AW'(first_idx);
        setup_d    = wsrc_data[first_idx*SRAM_DW +: SRAM_DW];
        setup_be_n = ~wsrc_mask[first_idx*BPB +: BPB];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        pend_d   = pend_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        base_d   = base_q;
        id_d     = id_q;
        rid_d    = '0;
        rdata_d  = rdata_q;
        turn_d   = turn_q;
        sram_a_d = sram_a_q;
        cs_n_d   = cs_n_q;
        oe_n_d   = oe_n_q;
        we_n_d   = we_n_q;
        be_n_d   = be_n_q;
        dout_d   = dout_q;
        drive_d  = drive_q;
        do_setup = 1'b0;

        case (state_q)
            S_IDLE: begin
                cs_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                be_n_d  = '1;
                drive_d = 1'b0;
                if (bus.mem_read) begin
                    state_d  = S_READ;
                    sram_a_d = req_base;
                    cs_n_d   = 1'b0;
                    oe_n_d   = 1'b0;
                    be_n_d   = '0;
                    cnt_d    = '0;
                    beat_d   = '0;
                    id_d     = bus.mem_id;
                    turn_d   = 1'b0;
                end else if (bus.mem_write) begin
                    wdata_d = bus.mem_writedata;
                    wmask_d = bus.mem_writedatamask;
                    base_d  = req_base;
                    pend_d  = req_nz;
                    cnt_d   = '0;
                    if (!first_ok) begin
                        state_d = S_WHOLD;
                    end else if ((TURNAROUND > 0) && turn_q) begin
                        state_d = S_TURN;
                    end else begin
                        do_setup = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (cnt_q == CW'(RWAIT - 1)) begin
                    cnt_d    = '0;
                    rdata_d  = rdata_shift;
                    sram_a_d = sram_a_q + SRAM_AW'(1);
                    beat_d   = beat_q + BW'(1);
                    if (((int'(beat_q) + 1) % K) == 0) begin
                        rid_d = id_q;
                    end
                    if (beat_q == BW'(NBEATS - 1)) begin
                        state_d = S_IDLE;
                        cs_n_d  = 1'b1;
                        oe_n_d  = 1'b1;
                        be_n_d  = '1;
                        turn_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_TURN: begin
                if (cnt_q == CW'(TURNAROUND - 1)) begin
                    turn_d   = 1'b0;
                    do_setup = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WSETUP: begin
                state_d = S_WPULSE;
                we_n_d  = 1'b0;
                cnt_d   = '0;
            end
            S_WPULSE: begin
                if (cnt_q == CW'(WWAIT - 1)) begin
                    state_d = S_WHOLD;
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WHOLD: begin
                if (first_ok) begin
                    do_setup = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    cs_n_d  = 1'b1;
                    be_n_d  = '1;
                    drive_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_setup) begin
            state_d  = S_WSETUP;
            sram_a_d = setup_a;
            dout_d   = setup_d;
            be_n_d   = setup_be_n;
            cs_n_d   = 1'b0;
            oe_n_d   = 1'b1;
            we_n_d   = 1'b1;
            drive_d  = 1'b1;
            pend_d   = pend_src & ~(K'(1) << first_idx);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            beat_q   <= '0;
            pend_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            base_q   <= '0;
            id_q     <= '0;
            rid_q    <= '0;
            rdata_q  <= '0;
            turn_q   <= 1'b0;
            sram_a_q <= '0;
            cs_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            be_n_q   <= '1;
            dout_q   <= '0;
            drive_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            pend_q   <= pend_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            base_q   <= base_d;
            id_q     <= id_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            turn_q   <= turn_d;
            sram_a_q <= sram_a_d;
            cs_n_q   <= cs_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            be_n_q   <= be_n_d;
            dout_q   <= dout_d;
            drive_q  <= drive_d;
        end
    end

    assign bus.mem_waitrequest = rst | (state_q != S_IDLE);
    assign bus.mem_readdata    = rdata_q;
    assign bus.mem_readdataid  = rid_q;
    assign sram_a              = sram_a_q;
    assign sram_cs_n           = cs_n_q;
    assign sram_oe_n           = oe_n_q;
    assign sram_we_n           = we_n_q;
    assign sram_be_n           = be_n_q;
    assign sram_d              = drive_q ? dout_q : 'z;
endmodule
